// File: rtl/load_store_unit_if.sv
// Bundled request, data-memory and writeback-response ports of the RV32I load/store unit.
// slave is the unit itself; master is the execute/memory/writeback environment around it.
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [4:0]            rsp_rd;
    logic                  rsp_reg_we;
    logic                  rsp_misaligned;
    logic                  rsp_illegal;
    logic [ADDR_WIDTH-1:0] rsp_addr;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output rsp_valid, rsp_data, rsp_rd, rsp_reg_we, rsp_misaligned, rsp_illegal, rsp_addr,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  rsp_valid, rsp_data, rsp_rd, rsp_reg_we, rsp_misaligned, rsp_illegal, rsp_addr,
        output rsp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one outstanding word-aligned memory access,
// byte-lane steering for stores, sign/zero extension for loads, fault reporting.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
    } req_t;

    state_t state, state_nx;
    req_t   cap;

    logic                  illegal, misaligned, fault;
    logic [3:0]            be_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic [1:0]            off;
    logic                  rsp_take;

    assign off = bus.req_addr[1:0];

    // funct3[1:0] encodes the access size (0 byte, 1 half, 2 word); funct3[2] is unsigned-load
    always_comb begin
        illegal    = bus.req_is_store ? (bus.req_funct3 > 3'd2)
                                      : (bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110);
        misaligned = !illegal && ((bus.req_funct3[1:0] == 2'd1 && off[0]) ||
                                  (bus.req_funct3[1:0] == 2'd2 && off != 2'b00));
        fault      = illegal || misaligned;
        case (bus.req_funct3[1:0])
            2'd0:    begin be_nx = 4'b0001 << off; wdata_nx = {4{bus.req_wdata[7:0]}};  end
            2'd1:    begin be_nx = 4'b0011 << off; wdata_nx = {2{bus.req_wdata[15:0]}}; end
            default: begin be_nx = 4'b1111;        wdata_nx = bus.req_wdata;            end
        endcase
        if (!bus.req_is_store) wdata_nx = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        case (state)
            IDLE:  if (bus.req_valid)     state_nx = fault ? RESP : ISSUE;
            ISSUE: if (bus.mem_req_ready) state_nx = bus.mem_rsp_valid ? RESP : WAIT;
            WAIT:  if (bus.mem_rsp_valid) state_nx = RESP;
            RESP:  if (bus.rsp_ready)     state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // A response can arrive in the same cycle the request is accepted
    assign rsp_take = bus.mem_rsp_valid &&
                      ((state == ISSUE && bus.mem_req_ready) || state == WAIT);

    logic [3:0][7:0]       rbytes;
    logic [1:0][15:0]      rhalves;
    logic [7:0]            bsel;
    logic [15:0]           hsel;
    logic [DATA_WIDTH-1:0] ld_ext;

    assign rbytes  = bus.mem_rdata;
    assign rhalves = bus.mem_rdata;

    always_comb begin
        bsel = rbytes[cap.off];
        hsel = rhalves[cap.off[1]];
        case (cap.funct3)
            3'b000:  ld_ext = {{24{bsel[7]}}, bsel};
            3'b001:  ld_ext = {{16{hsel[15]}}, hsel};
            3'b100:  ld_ext = {24'd0, bsel};
            3'b101:  ld_ext = {16'd0, hsel};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap                <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_be         <= '0;
            bus.mem_wdata      <= '0;
            bus.rsp_data       <= '0;
            bus.rsp_rd         <= '0;
            bus.rsp_reg_we     <= 1'b0;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_illegal    <= 1'b0;
            bus.rsp_addr       <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    cap                <= '{is_store: bus.req_is_store, funct3: bus.req_funct3, off: off};
                    bus.rsp_rd         <= bus.req_rd;
                    bus.rsp_addr       <= bus.req_addr;
                    bus.rsp_data       <= '0;
                    bus.rsp_reg_we     <= 1'b0;
                    bus.rsp_illegal    <= illegal;
                    bus.rsp_misaligned <= misaligned;
                    if (!fault) begin
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_we        <= bus.req_is_store;
                        bus.mem_addr      <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.mem_be        <= be_nx;
                        bus.mem_wdata     <= wdata_nx;
                    end
                end
                ISSUE: if (bus.mem_req_ready) bus.mem_req_valid <= 1'b0;
                default: ;
            endcase
            if (rsp_take && !cap.is_store) begin
                bus.rsp_data   <= ld_ext;
                bus.rsp_reg_we <= (bus.rsp_rd != 5'd0);
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed vectors push expected memory requests and
// responses; a negedge monitor pops and compares whenever the DUT hands something over.
module tb_load_store_unit;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
        logic        ill;
        logic [31:0] addr;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_hs = 0;
    int          mem_stall = 0;
    int          rsp_stall = 0;
    bit          mem_mute = 1'b0;
    bit          inject = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic void cmp_mem(string name, mem_exp_t e);
        logic [68:0] act, exp;
        act = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
        exp = {e.we, e.addr, e.be, e.wdata};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual{we,addr,be,wdata}=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic void cmp_rsp(string name, rsp_exp_t e);
        logic [71:0] act, exp;
        act = {bus.rsp_data, bus.rsp_rd, bus.rsp_reg_we, bus.rsp_misaligned, bus.rsp_illegal, bus.rsp_addr};
        exp = {e.data, e.rd, e.we, e.mis, e.ill, e.addr};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual{data,rd,we,mis,ill,addr}=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: compares every handshake, and every stalled cycle against the pending expectation
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.mem_req_valid) begin
                if (mem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL mem_unexpected actual=valid addr=%h expected=none", bus.mem_addr);
                end else if (bus.mem_req_ready) cmp_mem("mem_req", mem_q.pop_front());
                else cmp_mem("mem_req_stall", mem_q[0]);
            end
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rsp_unexpected actual=valid rd=%0d expected=none", bus.rsp_rd);
                end else if (bus.rsp_ready) cmp_rsp("rsp", rsp_q.pop_front());
                else cmp_rsp("rsp_stall", rsp_q[0]);
            end
        end
    end

    // One-cycle memory: response pulse the cycle after the request handshake
    initial begin
        bit pend;
        pend = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = 32'h0;
        bus.mem_req_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                n_hs++;
                pend = !mem_mute;
            end
            @(posedge clk); #1;
            bus.mem_rsp_valid = pend || inject;
            bus.mem_rdata     = (pend || inject) ? rdata_cfg : 32'h0;
            pend   = 1'b0;
            inject = 1'b0;
            bus.mem_req_ready = (mem_stall == 0);
            if (bus.mem_req_valid && mem_stall > 0) mem_stall--;
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.rsp_ready = (rsp_stall == 0);
            if (bus.rsp_valid && rsp_stall > 0) rsp_stall--;
        end
    end

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int lat);
        int n;
        @(posedge clk); #1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
        if (lat > 0) chk("latency", 32'(n), 32'(lat));
        n = 0;
        while (bus.rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);
        rst_n = 1'b1;

        // LW aligned
        rdata_cfg = 32'hDEADBEEF;
        mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{data: 32'hDEADBEEF, rd: 5'd5, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h100});
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 3);

        // LB / LBU on top byte
        rdata_cfg = 32'h80FF0000;
        mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'h0});
        rsp_q.push_back('{data: 32'hFFFFFF80, rd: 5'd6, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h103});
        do_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 3);
        mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'h0});
        rsp_q.push_back('{data: 32'h00000080, rd: 5'd7, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h103});
        do_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 3);

        // LH / LHU on upper half
        rdata_cfg = 32'h80011234;
        mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1100, wdata: 32'h0});
        rsp_q.push_back('{data: 32'hFFFF8001, rd: 5'd12, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h102});
        do_req(1'b0, 3'b001, 32'h102, 32'h0, 5'd12, 3);
        mem_q.push_back('{we: 1'b0, addr: 32'h104, be: 4'b1100, wdata: 32'h0});
        rsp_q.push_back('{data: 32'h00008001, rd: 5'd13, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h106});
        do_req(1'b0, 3'b101, 32'h106, 32'h0, 5'd13, 3);

        // LW to x0: data returned, no register write
        rdata_cfg = 32'h0BADF00D;
        mem_q.push_back('{we: 1'b0, addr: 32'h108, be: 4'hF, wdata: 32'h0});
        rsp_q.push_back('{data: 32'h0BADF00D, rd: 5'd0, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h108});
        do_req(1'b0, 3'b010, 32'h108, 32'h0, 5'd0, 3);

        // Stores: SH, SB, SW
        rdata_cfg = 32'h0;
        mem_q.push_back('{we: 1'b1, addr: 32'h200, be: 4'b1100, wdata: 32'hABCDABCD});
        rsp_q.push_back('{data: 32'h0, rd: 5'd8, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h202});
        do_req(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 5'd8, 3);
        mem_q.push_back('{we: 1'b1, addr: 32'h300, be: 4'b0010, wdata: 32'hA5A5A5A5});
        rsp_q.push_back('{data: 32'h0, rd: 5'd1, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h301});
        do_req(1'b1, 3'b000, 32'h301, 32'h000000A5, 5'd1, 3);
        mem_q.push_back('{we: 1'b1, addr: 32'h10, be: 4'hF, wdata: 32'h11223344});
        rsp_q.push_back('{data: 32'h0, rd: 5'd2, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h10});
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344, 5'd2, 3);

        // Faults: misaligned, illegal store, illegal load, illegal+misaligned
        hs0 = n_hs;
        rsp_q.push_back('{data: 32'h0, rd: 5'd9, we: 1'b0, mis: 1'b1, ill: 1'b0, addr: 32'h101});
        do_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd9, 1);
        rsp_q.push_back('{data: 32'h0, rd: 5'd4, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h103});
        rsp_q[0].mis = 1'b1;
        do_req(1'b0, 3'b101, 32'h103, 32'h0, 5'd4, 1);
        rsp_q.push_back('{data: 32'h0, rd: 5'd0, we: 1'b0, mis: 1'b0, ill: 1'b1, addr: 32'h104});
        do_req(1'b1, 3'b011, 32'h104, 32'hFFFFFFFF, 5'd0, 1);
        rsp_q.push_back('{data: 32'h0, rd: 5'd14, we: 1'b0, mis: 1'b0, ill: 1'b1, addr: 32'h104});
        do_req(1'b0, 3'b110, 32'h104, 32'h0, 5'd14, 1);
        rsp_q.push_back('{data: 32'h0, rd: 5'd15, we: 1'b0, mis: 1'b0, ill: 1'b1, addr: 32'h101});
        do_req(1'b0, 3'b011, 32'h101, 32'h0, 5'd15, 1);
        chk("faults_no_mem", 32'(n_hs - hs0), 32'd0);

        // Backpressure on both sides
        hs0 = n_hs;
        mem_stall = 3;
        rsp_stall = 2;
        mem_q.push_back('{we: 1'b1, addr: 32'h40, be: 4'hF, wdata: 32'hCAFEF00D});
        rsp_q.push_back('{data: 32'h0, rd: 5'd3, we: 1'b0, mis: 1'b0, ill: 1'b0, addr: 32'h40});
        do_req(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd3, -1);
        chk("one_handshake", 32'(n_hs - hs0), 32'd1);

        // Reset while waiting for memory, then a stray response
        mem_mute = 1'b1;
        mem_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0});
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h300; bus.req_rd = 5'd11;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mid_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mid_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mid_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mid_rsp_rd", 32'(bus.rsp_rd), 32'd0);
        chk("rst_mid_rsp_addr", bus.rsp_addr, 32'd0);
        chk("rst_mid_rsp_flags", 32'({bus.rsp_valid, bus.rsp_reg_we, bus.rsp_misaligned, bus.rsp_illegal}), 32'd0);
        chk("rst_mid_rsp_data", bus.rsp_data, 32'd0);
        @(negedge clk);
        rdata_cfg = 32'h55555555;
        inject    = 1'b1;
        mem_mute  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk("stray_rsp_ignored", 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        end

        rdata_cfg = 32'h12347FFE;
        mem_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'b0011, wdata: 32'h0});
        rsp_q.push_back('{data: 32'h00007FFE, rd: 5'd10, we: 1'b1, mis: 1'b0, ill: 1'b0, addr: 32'h200});
        do_req(1'b0, 3'b001, 32'h200, 32'h0, 5'd10, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
